// File: rtl/rr_agg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_agg_pkg
// Description : Shared types and helpers for the round-robin FIFO aggregator.
//               gate_state_t - duty-cycle gate FSM encoding.
//               CHAN_W()     - width of a channel index, never less than 1.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_agg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLOCK = 2'd1,
        PASS  = 2'd2
    } gate_state_t;

    // A two-client system still needs one bit to name its channels.
    function automatic int CHAN_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_agg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rr_agg_fifo
// Description : Synchronous FIFO with an occupancy count output. A write while
//               full is refused even when a read happens at the same edge; a
//               read while empty is ignored. Head data is presented
//               combinationally (first-word fall-through).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_wr_en/i_wr_data - write request and payload
//               i_rd_en           - pop the head entry
//               o_rd_data         - head entry
//               o_count           - registered occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module rr_agg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    // Depth is a power of two, so the address pointers wrap naturally and the
    // separate count register disambiguates full from empty.
    assign w_do_wr = i_wr_en && (r_count != c_DEPTH);
    assign w_do_rd = i_rd_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/rr_fifo_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : rr_fifo_aggregator
// Description : CLIENTS ingress FIFOs merged into one egress FIFO by a
//               round-robin arbiter, one grant per cycle. A duty-cycle gate
//               can periodically block grants (BLOCK for gate_high cycles,
//               PASS for gate_low cycles). Each egress entry carries the
//               source channel index alongside the payload.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid/in_data     - per-channel write request and payload
//               in_ready             - per-channel ingress FIFO not full
//               gate_en              - enable the duty-cycle gate
//               gate_high/gate_low   - blocked / pass phase lengths in cycles
//               out_valid/out_ready  - egress handshake
//               out_data/out_chan    - egress head payload and source channel
// Revision    : 1.0 - initial release
// ============================================================================
module rr_fifo_aggregator
    import rr_agg_pkg::*;
#(
    parameter int CLIENTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int GATE_W     = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CLIENTS-1:0]            in_valid,
    input  logic [CLIENTS*DATA_WIDTH-1:0] in_data,
    output logic [CLIENTS-1:0]            in_ready,
    input  logic                          gate_en,
    input  logic [GATE_W-1:0]             gate_high,
    input  logic [GATE_W-1:0]             gate_low,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [CHAN_W(CLIENTS)-1:0]    out_chan
);

    localparam int               c_CW        = CHAN_W(CLIENTS);
    localparam int               c_EW        = c_CW + DATA_WIDTH;
    localparam int               c_IAW       = $clog2(IN_DEPTH);
    localparam int               c_OAW       = $clog2(OUT_DEPTH);
    localparam logic [c_IAW:0]   c_IN_DEPTH  = (c_IAW + 1)'(IN_DEPTH);
    localparam logic [c_OAW:0]   c_OUT_DEPTH = (c_OAW + 1)'(OUT_DEPTH);
    localparam logic [c_CW:0]    c_CLIENTS   = (c_CW + 1)'(CLIENTS);
    localparam logic [c_CW-1:0]  c_LAST_CH   = c_CW'(CLIENTS - 1);

    // ------------------------------------------------------------------
    // Ingress FIFOs
    // ------------------------------------------------------------------
    logic [CLIENTS-1:0]    w_wr;
    logic [CLIENTS-1:0]    w_req;
    logic [CLIENTS-1:0]    w_grant;
    logic [DATA_WIDTH-1:0] w_in_head  [CLIENTS];
    logic [c_IAW:0]        w_in_count [CLIENTS];

    for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_ingress
        // Readiness comes from the registered count only, so a pop at the
        // same edge never lets a full FIFO accept a word.
        assign in_ready[gi] = !rst && (w_in_count[gi] != c_IN_DEPTH);
        assign w_wr[gi]     = in_valid[gi] && in_ready[gi];
        assign w_req[gi]    = (w_in_count[gi] != '0);

        rr_agg_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (IN_DEPTH)
        ) u_in_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr[gi]),
            .i_wr_data (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_rd_en   (w_grant[gi]),
            .o_rd_data (w_in_head[gi]),
            .o_count   (w_in_count[gi])
        );
    end

    // ------------------------------------------------------------------
    // Duty-cycle gate: state register / next-state / output
    // ------------------------------------------------------------------
    gate_state_t       r_gate_state;
    gate_state_t       w_gate_state_nxt;
    logic [GATE_W-1:0] r_phase_cnt;
    logic [GATE_W-1:0] w_phase_cnt_nxt;
    logic [GATE_W-1:0] w_low_m1;
    logic              w_gate_block;

    // A zero-length pass phase is stretched to one cycle so the gate can
    // never lock grants out permanently.
    assign w_low_m1 = (gate_low == '0) ? '0 : gate_low - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_state <= IDLE;
            r_phase_cnt  <= '0;
        end else begin
            r_gate_state <= w_gate_state_nxt;
            r_phase_cnt  <= w_phase_cnt_nxt;
        end
    end

    always_comb begin
        w_gate_state_nxt = r_gate_state;
        w_phase_cnt_nxt  = r_phase_cnt;
        if (!gate_en) begin
            w_gate_state_nxt = IDLE;
            w_phase_cnt_nxt  = '0;
        end else begin
            case (r_gate_state)
                IDLE: begin
                    if (gate_high != '0) begin
                        w_gate_state_nxt = BLOCK;
                        w_phase_cnt_nxt  = gate_high - 1'b1;
                    end
                end
                BLOCK: begin
                    if (r_phase_cnt == '0) begin
                        w_gate_state_nxt = PASS;
                        w_phase_cnt_nxt  = w_low_m1;
                    end else begin
                        w_phase_cnt_nxt  = r_phase_cnt - 1'b1;
                    end
                end
                PASS: begin
                    if (r_phase_cnt == '0) begin
                        if (gate_high == '0) begin
                            w_gate_state_nxt = IDLE;
                            w_phase_cnt_nxt  = '0;
                        end else begin
                            w_gate_state_nxt = BLOCK;
                            w_phase_cnt_nxt  = gate_high - 1'b1;
                        end
                    end else begin
                        w_phase_cnt_nxt  = r_phase_cnt - 1'b1;
                    end
                end
                default: begin
                    w_gate_state_nxt = IDLE;
                    w_phase_cnt_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_gate_block = (r_gate_state == BLOCK);
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [c_CW-1:0] r_ptr;
    logic [c_CW-1:0] w_gnt_idx;
    logic            w_gnt_found;
    logic            w_do_grant;
    logic [c_OAW:0]  w_out_count;

    // Scan channels starting at the priority pointer; the first requester
    // found wins. The extended index absorbs the wrap past CLIENTS-1.
    always_comb begin
        logic [c_CW:0] w_scan_idx;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < CLIENTS; k++) begin
            w_scan_idx = {1'b0, r_ptr} + (c_CW + 1)'(k);
            if (w_scan_idx >= c_CLIENTS) begin
                w_scan_idx = w_scan_idx - c_CLIENTS;
            end
            if (!w_gnt_found && w_req[w_scan_idx[c_CW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx[c_CW-1:0];
            end
        end
    end

    // Egress must have room by its registered count; a pop at the same
    // edge does not make room for a grant.
    assign w_do_grant = !rst && w_gnt_found && !w_gate_block &&
                        (w_out_count != c_OUT_DEPTH);
    assign w_grant    = w_do_grant ? (CLIENTS'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_do_grant) begin
            r_ptr <= (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Egress FIFO: entries are {channel index, payload}
    // ------------------------------------------------------------------
    logic [c_EW-1:0] w_eg_wr_data;
    logic [c_EW-1:0] w_eg_head;
    logic            w_eg_rd;

    assign w_eg_wr_data = {w_gnt_idx, w_in_head[w_gnt_idx]};
    assign w_eg_rd      = out_valid && out_ready;

    rr_agg_fifo #(
        .WIDTH (c_EW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_do_grant),
        .i_wr_data (w_eg_wr_data),
        .i_rd_en   (w_eg_rd),
        .o_rd_data (w_eg_head),
        .o_count   (w_out_count)
    );

    // Outputs are forced to zero whenever no valid head is presented, which
    // also covers the whole reset interval.
    assign out_valid = !rst && (w_out_count != '0);
    assign out_data  = out_valid ? w_eg_head[DATA_WIDTH-1:0]      : '0;
    assign out_chan  = out_valid ? w_eg_head[DATA_WIDTH +: c_CW]  : '0;

endmodule
`default_nettype wire

// File: doc/rr_fifo_aggregator.md
RR_FIFO_AGGREGATOR -- requirements
Module: rr_fifo_aggregator

Interface
REQ-001 SHALL have parameter CLIENTS, default 4: number of ingress channels, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload width.
REQ-003 SHALL have parameter IN_DEPTH, default 4: per-channel ingress FIFO depth, power of 2, >=2.
REQ-004 SHALL have parameter OUT_DEPTH, default 4: egress FIFO depth, power of 2, >=2.
REQ-005 SHALL have parameter GATE_W, default 11: width of the gate phase counters.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  in  CLIENTS  per-channel write request.
REQ-009 SHALL have port in_data  in  CLIENTS*DATA_WIDTH  channel i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port in_ready  out  CLIENTS  per-channel ingress FIFO not full.
REQ-011 SHALL have port gate_en  in  1  enables the duty-cycle grant gate.
REQ-012 SHALL have port gate_high  in  GATE_W  blocked-phase length, in cycles.
REQ-013 SHALL have port gate_low  in  GATE_W  pass-phase length, in cycles.
REQ-014 SHALL have port out_valid  out  1  egress FIFO not empty.
REQ-015 SHALL have port out_ready  in  1  downstream accept.
REQ-016 SHALL have port out_data  out  DATA_WIDTH  egress head payload.
REQ-017 SHALL have port out_chan  out  max(1,$clog2(CLIENTS))  source channel of the egress head.

Function
REQ-018 SHALL write channel i's ingress FIFO when in_valid[i] && in_ready[i]; in_ready[i] = registered count < IN_DEPTH.
REQ-019 SHALL treat a channel as requesting when its registered ingress count > 0; no same-cycle input-to-grant bypass.
REQ-020 SHALL grant at most one channel per cycle, one-hot, and only when egress count < OUT_DEPTH and gate is not BLOCK.
REQ-021 SHALL, on grant, pop the granted ingress head and push {channel index, payload} into the egress FIFO at the same edge.
REQ-022 SHALL arbitrate round-robin: search starts at the priority pointer; after a grant to channel g, pointer = (g+1) mod CLIENTS; pointer holds when there is no grant.
REQ-023 SHALL give minimum latency of 2 cycles: in_valid accepted at edge k -> out_valid high after edge k+1.
REQ-024 SHALL allow a simultaneous push and pop on any FIFO; a full ingress FIFO refuses the write (in_ready low) even if popped that cycle.
REQ-025 SHALL pop egress when out_valid && out_ready; out_data/out_chan stay stable while out_valid && !out_ready.
REQ-026 SHALL implement gate FSM states IDLE, BLOCK, PASS with a GATE_W-bit phase counter.
REQ-027 IDLE: grants allowed; if gate_en && gate_high != 0 -> BLOCK with counter=gate_high-1.
REQ-028 BLOCK: grants blocked; counter decrements; at 0 -> PASS with counter=max(gate_low,1)-1.
REQ-029 PASS: grants allowed; counter decrements; at 0 -> BLOCK with counter=gate_high-1, or -> IDLE if gate_high == 0.
REQ-030 SHALL go to IDLE at the next edge from any state when gate_en is deasserted; gate_high/gate_low are sampled only at phase entry.
REQ-031 SHALL keep all FIFO pointers wrap-safe using an extra MSB, or equivalent count registers.

Reset
REQ-032 SHALL, while rst is high, clear all counts and pointers and set the priority pointer to 0, the gate FSM to IDLE and the phase counter to 0.
REQ-033 SHALL drive in_ready=0, out_valid=0, out_data=0 and out_chan=0 while rst is high; in_ready rises in the cycle after rst deasserts.
REQ-034 SHALL discard in-flight data when rst asserts mid-operation; no grant or pop occurs at that edge.

Structure
REQ-035 SHALL place the gate_state_t enum (IDLE, BLOCK, PASS) and a CHAN_W width function in package rr_agg_pkg.
REQ-036 SHALL use one sub-module, rr_agg_fifo (sync FIFO, active-high sync reset, parameterised width/depth, count output), instantiated CLIENTS+1 times; the arbiter and gate are inline.

Verification
REQ-037 Single word: channel 2 writes 0xA5 at edge 0, gate_en=0, out_ready=1 -> out_valid high after edge 1 with out_data=0xA5 and out_chan=2.
REQ-038 Fairness: all 4 channels hold 4 words, out_ready=1 -> egress channel order 0,1,2,3,0,1,2,3,... with no channel granted twice in a row.
REQ-039 Backpressure: out_ready=0 with 8 words queued -> exactly OUT_DEPTH=4 grants, then none; head stable; one out_ready pulse -> exactly one further grant.
REQ-040 Gate: gate_en=1, gate_high=3, gate_low=2, all channels loaded -> repeating pattern of 3 cycles without grants and 2 cycles with grants; deasserting gate_en -> grants in every cycle from the next cycle.
REQ-041 Full ingress: 5 writes to channel 0 with out_ready=0 -> in_ready[0] low after the 4th write while no grant pops it (egress full), 5th word dropped; reset asserted mid-stream -> out_valid=0 and in_ready=0 during reset, with empty FIFOs after reset.
